// File: rtl/egress_port_reader.sv
// Per-port egress engine: queues frame start pointers, walks each frame's cell chain and streams it to the MAC.
// Define EGRESS_IFG_EN to insert IFG_CYCLES idle cycles (GAP state) after each completed frame.

package mem_pkg;
  localparam int ADDR_W = 8;
endpackage

module egress_port_reader #(
  parameter int ADDR_W      = mem_pkg::ADDR_W,
  parameter int DATA_W      = 8,
  parameter int QUEUE_DEPTH = 16,
  parameter int IFG_CYCLES  = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             write_req_i,
  input  logic [ADDR_W-1:0]                start_ptr_i,
  output logic                             queue_full_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count_o,
  output logic                             drop_o,
  output logic                             mem_rd_en_o,
  output logic [ADDR_W-1:0]                mem_rd_addr_o,
  input  logic                             mem_rd_valid_i,
  input  logic [DATA_W-1:0]                mem_rd_data_i,
  input  logic                             mem_rd_eop_i,
  input  logic [ADDR_W-1:0]                mem_rd_next_ptr_i,
  output logic [DATA_W-1:0]                tx_data_o,
  output logic                             tx_valid_o,
  output logic                             tx_last_o,
  input  logic                             tx_ready_i,
  output logic                             frame_done_o,
  output logic [ADDR_W-1:0]                frame_done_ptr_o,
  output logic [2:0]                       dbg_state
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
`ifdef EGRESS_IFG_EN
    ,
    S_GAP   = 3'd5
`endif
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              full_q, drop_q;
  logic              push, pop;

  logic [ADDR_W-1:0] cur_ptr, start_reg, next_reg;
  logic [DATA_W-1:0] data_reg;
  logic              eop_reg;

  // Full/drop decisions use the pre-cycle count, so a same-cycle pop never rescues a push into a full queue.
  assign push = write_req_i && (count != FULL_CNT);
  assign pop  = (state == S_IDLE) && (count != '0);

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count_nxt;
      full_q <= (count_nxt == FULL_CNT);
      drop_q <= write_req_i && (count == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= start_ptr_i;
  end

  assign queue_count_o = count;
  assign queue_full_o  = full_q;
  assign drop_o        = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ptr   <= '0;
      start_reg <= '0;
      next_reg  <= '0;
      data_reg  <= '0;
      eop_reg   <= 1'b0;
    end else begin
      if (pop) begin
        cur_ptr   <= fifo_mem[rd_ptr];
        start_reg <= fifo_mem[rd_ptr];
      end
      if ((state == S_WAIT) && mem_rd_valid_i) begin
        data_reg <= mem_rd_data_i;
        eop_reg  <= mem_rd_eop_i;
        next_reg <= mem_rd_next_ptr_i;
      end
      if ((state == S_SEND) && tx_ready_i && !eop_reg) begin
        cur_ptr <= next_reg;
      end
    end
  end

`ifdef EGRESS_IFG_EN
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state == S_DONE) begin
      gap_cnt <= GAP_W'(IFG_CYCLES - 1);
    end else if ((state == S_GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end
`else
  logic ifg_unused;
  assign ifg_unused = (IFG_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count != '0) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  if (mem_rd_valid_i) state_nxt = S_SEND;
      S_SEND:  if (tx_ready_i) state_nxt = eop_reg ? S_DONE : S_FETCH;
`ifdef EGRESS_IFG_EN
      S_DONE:  state_nxt = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == '0) state_nxt = S_IDLE;
`else
      S_DONE:  state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // tx handshake: a beat transfers on a cycle with tx_valid_o && tx_ready_i; once raised, tx_valid_o,
  // tx_data_o and tx_last_o hold until that transfer, and tx_ready_i has no effect while tx_valid_o is low.
  always_comb begin
    mem_rd_en_o      = 1'b0;
    mem_rd_addr_o    = '0;
    tx_valid_o       = 1'b0;
    tx_data_o        = '0;
    tx_last_o        = 1'b0;
    frame_done_o     = 1'b0;
    frame_done_ptr_o = '0;
    case (state)
      S_FETCH: begin
        mem_rd_en_o   = 1'b1;
        mem_rd_addr_o = cur_ptr;
      end
      S_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = data_reg;
        tx_last_o  = eop_reg;
      end
      S_DONE: begin
        frame_done_o     = 1'b1;
        frame_done_ptr_o = start_reg;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_egress_port_reader.sv
// Directed bench for egress_port_reader: memory responder, frame-level scoreboard and cycle checks.
// Timing expectations for the inter-frame gap follow EGRESS_IFG_EN.
`timescale 1ns/1ps
module tb_egress_port_reader;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int QUEUE_DEPTH = 16;
  localparam int IFG_CYCLES  = 12;
  localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              write_req_i;
  logic [ADDR_W-1:0] start_ptr_i;
  logic              queue_full_o;
  logic [CNT_W-1:0]  queue_count_o;
  logic              drop_o;
  logic              mem_rd_en_o;
  logic [ADDR_W-1:0] mem_rd_addr_o;
  logic              mem_rd_valid_i;
  logic [DATA_W-1:0] mem_rd_data_i;
  logic              mem_rd_eop_i;
  logic [ADDR_W-1:0] mem_rd_next_ptr_i;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_valid_o;
  logic              tx_last_o;
  logic              tx_ready_i;
  logic              frame_done_o;
  logic [ADDR_W-1:0] frame_done_ptr_o;
  logic [2:0]        dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  egress_port_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .QUEUE_DEPTH(QUEUE_DEPTH), .IFG_CYCLES(IFG_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .write_req_i(write_req_i), .start_ptr_i(start_ptr_i),
    .queue_full_o(queue_full_o), .queue_count_o(queue_count_o), .drop_o(drop_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_valid_i(mem_rd_valid_i),
    .mem_rd_data_i(mem_rd_data_i), .mem_rd_eop_i(mem_rd_eop_i), .mem_rd_next_ptr_i(mem_rd_next_ptr_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o), .tx_ready_i(tx_ready_i),
    .frame_done_o(frame_done_o), .frame_done_ptr_o(frame_done_ptr_o), .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // packet memory model
  logic [DATA_W-1:0] cell_data [256];
  logic              cell_eop  [256];
  logic [ADDR_W-1:0] cell_next [256];
  int                mem_lat = 1;

  // scoreboard
  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [DATA_W:0]   exp_beat_q[$];
  logic [ADDR_W-1:0] exp_done_q[$];
  logic [ADDR_W-1:0] rd_log[$];
  logic [DATA_W:0]   beat_log[$];
  int                tx_cyc_log[$];

  int                cyc = 0;
  int                push_cyc = 0, rd_cyc = 0, done_cyc = 0;
  int                done_cnt = 0, drop_cnt = 0;
  logic [ADDR_W-1:0] done_ptr = '0;
  logic              reject = 1'b0;
  logic              drop_exp = 1'b0;
  logic              prev_stall = 1'b0;
  logic [DATA_W:0]   prev_beat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_event(input string name, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h, required no event", name, act);
  endtask

  task automatic set_cell(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic e, input logic [ADDR_W-1:0] n);
    cell_data[a] = d;
    cell_eop[a]  = e;
    cell_next[a] = n;
  endtask

  // model of one accepted frame: follow the chain in the memory table
  task automatic expect_frame(input logic [ADDR_W-1:0] p);
    logic [ADDR_W-1:0] a;
    a = p;
    for (int k = 0; k < 64; k++) begin
      exp_rd_q.push_back(a);
      exp_beat_q.push_back({cell_eop[a], cell_data[a]});
      if (cell_eop[a]) break;
      a = cell_next[a];
    end
    exp_done_q.push_back(p);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    beat_log.delete();
    tx_cyc_log.delete();
  endtask

  // driver tasks
  task automatic push(input logic [ADDR_W-1:0] p, input logic accept);
    @(negedge clk);
    write_req_i = 1'b1;
    start_ptr_i = p;
    reject      = !accept;
    if (accept) expect_frame(p);
  endtask

  task automatic push_end();
    @(negedge clk);
    write_req_i = 1'b0;
    start_ptr_i = '0;
    reject      = 1'b0;
  endtask

  task automatic wait_tx_valid(input string name);
    int n;
    n = 0;
    while (!tx_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, tx_valid_o, 1'b1);
  endtask

  task automatic wait_rd_en(input string name);
    int n;
    n = 0;
    while (!mem_rd_en_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, mem_rd_en_o, 1'b1);
  endtask

  task automatic wait_drain(input string name, input logic [7:0] rdy_pat, input int max);
    int n;
    n = 0;
    while (exp_done_q.size() != 0 && n < max) begin
      tx_ready_i = rdy_pat[n % 8];
      @(negedge clk);
      n++;
    end
    tx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check(name, exp_done_q.size(), 0);
    exp_rd_q.delete();
    exp_beat_q.delete();
    exp_done_q.delete();
  endtask

  // memory responder: one outstanding read, answered mem_lat cycles after the request
  logic              pend = 1'b0;
  int                pend_wait = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  always @(negedge clk) begin
    mem_rd_valid_i    = 1'b0;
    mem_rd_data_i     = '0;
    mem_rd_eop_i      = 1'b0;
    mem_rd_next_ptr_i = '0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pend_wait <= 1) begin
          mem_rd_valid_i    = 1'b1;
          mem_rd_data_i     = cell_data[pend_addr];
          mem_rd_eop_i      = cell_eop[pend_addr];
          mem_rd_next_ptr_i = cell_next[pend_addr];
          pend              = 1'b0;
        end else begin
          pend_wait--;
        end
      end
      if (mem_rd_en_o) begin
        pend      = 1'b1;
        pend_wait = mem_lat;
        pend_addr = mem_rd_addr_o;
      end
    end
  end

  // compare process: every cycle, after inputs for the cycle are settled
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      check("reset_outputs",
            {tx_valid_o, tx_last_o, mem_rd_en_o, frame_done_o, drop_o, queue_full_o,
             tx_data_o, mem_rd_addr_o, frame_done_ptr_o, queue_count_o, dbg_state}, '0);
      exp_rd_q.delete();
      exp_beat_q.delete();
      exp_done_q.delete();
      prev_stall = 1'b0;
      drop_exp   = 1'b0;
    end else begin
      if (mem_rd_en_o) begin
        rd_log.push_back(mem_rd_addr_o);
        rd_cyc = cyc;
        if (exp_rd_q.size() == 0) fail_event("unexpected_read", mem_rd_addr_o);
        else check("read_addr", mem_rd_addr_o, exp_rd_q.pop_front());
      end
      if (prev_stall) begin
        check("tx_hold_valid", tx_valid_o, 1'b1);
        check("tx_hold_beat", {tx_last_o, tx_data_o}, prev_beat);
      end
      if (tx_valid_o) check("no_read_in_send", mem_rd_en_o, 1'b0);
      if (tx_valid_o && tx_ready_i) begin
        beat_log.push_back({tx_last_o, tx_data_o});
        tx_cyc_log.push_back(cyc);
        if (exp_beat_q.size() == 0) fail_event("unexpected_beat", {tx_last_o, tx_data_o});
        else check("tx_beat", {tx_last_o, tx_data_o}, exp_beat_q.pop_front());
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_beat  = {tx_last_o, tx_data_o};
      if (frame_done_o) begin
        done_cnt++;
        done_cyc = cyc;
        done_ptr = frame_done_ptr_o;
        if (exp_done_q.size() == 0) fail_event("unexpected_done", frame_done_ptr_o);
        else check("done_ptr", frame_done_ptr_o, exp_done_q.pop_front());
      end
      check("drop", drop_o, drop_exp);
      if (drop_o) drop_cnt++;
      drop_exp = write_req_i && reject;
      if (write_req_i) push_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  int gap;
  int d0;

  initial begin
    rst_n       = 1'b0;
    write_req_i = 1'b0;
    start_ptr_i = '0;
    tx_ready_i  = 1'b1;
    for (int a = 0; a < 256; a++) set_cell(ADDR_W'(a), DATA_W'(a) ^ 8'h5A, 1'b1, '0);
    set_cell(8'h10, 8'hAA, 1'b1, 8'h00);
    set_cell(8'h20, 8'h01, 1'b0, 8'h21);
    set_cell(8'h21, 8'h02, 1'b0, 8'h35);
    set_cell(8'h35, 8'h03, 1'b1, 8'h00);
    set_cell(8'h70, 8'h77, 1'b0, 8'h71);
    set_cell(8'h71, 8'h78, 1'b1, 8'h00);
    set_cell(8'h60, 8'h66, 1'b1, 8'h00);
    set_cell(8'h50, 8'h55, 1'b1, 8'h00);
    set_cell(8'h40, 8'h44, 1'b1, 8'h00);
    for (int i = 0; i < 17; i++) set_cell(ADDR_W'(8'h80 + i), DATA_W'(i), 1'b1, 8'h00);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("count_after_reset", queue_count_o, 0);
    check("idle_after_reset", {tx_valid_o, mem_rd_en_o, queue_full_o}, 3'b000);

    // single-cell frame, 1-cycle memory: read +2, beat +4, done +5 after the push
    clear_logs();
    push(8'h10, 1'b1);
    push_end();
    wait_drain("t1_drain", 8'hFF, 40);
    check("t1_rd_latency", rd_cyc - push_cyc, 2);
    check("t1_tx_latency", tx_cyc_log[0] - push_cyc, 4);
    check("t1_done_latency", done_cyc - push_cyc, 5);
    check("t1_rd_addr", rd_log[0], 8'h10);
    check("t1_beat", beat_log[0], 9'h1AA);
    check("t1_done_ptr", done_ptr, 8'h10);

    // three-cell chain
    clear_logs();
    push(8'h20, 1'b1);
    push_end();
    wait_drain("t2_drain", 8'hFF, 60);
    check("t2_reads", rd_log.size(), 3);
    check("t2_rd0", rd_log[0], 8'h20);
    check("t2_rd1", rd_log[1], 8'h21);
    check("t2_rd2", rd_log[2], 8'h35);
    check("t2_beat0", beat_log[0], 9'h001);
    check("t2_beat1", beat_log[1], 9'h002);
    check("t2_beat2", beat_log[2], 9'h103);

    // backpressure for 5 cycles on the first beat
    clear_logs();
    tx_ready_i = 1'b0;
    push(8'h70, 1'b1);
    push_end();
    wait_tx_valid("t3_valid_rise");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_stall_beat", {tx_valid_o, tx_last_o, tx_data_o, mem_rd_en_o}, {1'b1, 1'b0, 8'h77, 1'b0});
    end
    wait_drain("t3_drain", 8'hFF, 60);
    check("t3_beats", beat_log.size(), 2);
    check("t3_beat1", beat_log[1], 9'h178);

    // fill the queue while a frame is stalled in SEND, 17th push is dropped
    tx_ready_i = 1'b0;
    drop_cnt   = 0;
    push(8'h60, 1'b1);
    push_end();
    wait_tx_valid("t4_valid_rise");
    for (int i = 0; i < 17; i++) push(ADDR_W'(8'h80 + i), (i < 16));
    push_end();
    for (int i = 0; i < 3; i++) begin
      check("t4_count_full", {queue_full_o, queue_count_o}, {1'b1, CNT_W'(16)});
      @(negedge clk);
    end
    check("t4_drop_once", drop_cnt, 1);
    wait_drain("t4_drain", 8'hFF, 400);
    check("t4_drained", {queue_full_o, queue_count_o}, '0);
    check("t4_drop_total", drop_cnt, 1);

    // reset while waiting on a slow memory read
    mem_lat = 6;
    d0 = done_cnt;
    push(8'h50, 1'b1);
    push_end();
    wait_rd_en("t5_read_issued");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_reset_now", {tx_valid_o, mem_rd_en_o, frame_done_o, queue_full_o, queue_count_o}, '0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    mem_lat = 1;
    repeat (8) @(negedge clk);
    check("t5_no_done", done_cnt, d0);
    push(8'h40, 1'b1);
    push_end();
    wait_drain("t5_drain", 8'hFF, 40);
    check("t5_one_done", done_cnt, d0 + 1);
    check("t5_done_ptr", done_ptr, 8'h40);

    // mixed: queued frames with slower memory and intermittent ready
    mem_lat = 3;
    clear_logs();
    push(8'h20, 1'b1);
    push(8'h70, 1'b1);
    push(8'h10, 1'b1);
    push_end();
    wait_drain("t6_drain", 8'b1011_0010, 300);
    check("t6_beats", beat_log.size(), 6);

    // spacing between back-to-back single-cell frames
    mem_lat = 1;
    clear_logs();
    push(8'h10, 1'b1);
    push(8'h60, 1'b1);
    push_end();
    wait_drain("t7_drain", 8'hFF, 80);
    check("t7_beats", tx_cyc_log.size(), 2);
    gap = tx_cyc_log[1] - tx_cyc_log[0] - 1;
`ifdef EGRESS_IFG_EN
    check("t7_ifg_min", (gap >= IFG_CYCLES), 1'b1);
`else
    check("t7_gap", gap, 4);
`endif

    check("final_queues_empty", exp_rd_q.size() + exp_beat_q.size() + exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/egress_port_reader.md
Name: egress_port_reader

Overview:
- Per-port egress engine; one instance per switch port, fed by that port's write request and start pointer from the forwarding stage.
- Queues frame start pointers, then walks each frame's linked cell chain in packet memory.
- Streams the data words to the port's MAC transmitter with a valid/ready handshake.
- Reports completion of each frame so the central buffer manager can release or decrement cells.

Parameters:
- ADDR_W, mem_pkg::ADDR_W, packet memory cell address width
- DATA_W, 8, data bits per memory cell word and per tx beat
- QUEUE_DEPTH, 16, start-pointer FIFO entries (power of two, >=2)
- IFG_CYCLES, 12, idle cycles between frames (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- write_req_i  in  1  enqueue start_ptr_i this cycle
- start_ptr_i  in  ADDR_W  first cell of the frame
- queue_full_o  in/out: out  1  count == QUEUE_DEPTH
- queue_count_o  out  $clog2(QUEUE_DEPTH+1)  entries held
- drop_o  out  1  one-cycle pulse: a write_req_i was rejected because the queue was full
- mem_rd_en_o  out  1  one-cycle read request
- mem_rd_addr_o  out  ADDR_W  cell address to read
- mem_rd_valid_i  in  1  read data returned
- mem_rd_data_i  in  DATA_W  cell data
- mem_rd_eop_i  in  1  cell is the last cell of the frame
- mem_rd_next_ptr_i  in  ADDR_W  next cell address (ignored when eop)
- tx_data_o  out  DATA_W  data to MAC
- tx_valid_o  out  1  tx beat valid
- tx_last_o  out  1  beat is the last of the frame
- tx_ready_i  in  1  MAC accepts the beat
- frame_done_o  out  1  one-cycle pulse: frame fully transmitted
- frame_done_ptr_o  out  ADDR_W  start pointer of the completed frame

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs are 0 and queue_count_o is 0.
  - FIFO pointers are cleared and the FSM goes to IDLE.
  - A frame in flight at reset is abandoned; no frame_done_o is issued for it.
- FIFO rules:
  - Push on write_req_i when the pre-cycle count < QUEUE_DEPTH.
  - If the pre-cycle count == QUEUE_DEPTH, the push is dropped and drop_o pulses the next cycle. This holds even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count is unchanged.
  - Read and write pointers wrap modulo QUEUE_DEPTH.
  - queue_full_o and queue_count_o are registered.
- FSM states: IDLE, FETCH, WAIT, SEND, DONE.
  - IDLE: if count != 0, pop the head into cur_ptr and start_reg, then go to FETCH. A push at cycle N is poppable at N+1.
  - FETCH: drive mem_rd_en_o=1 and mem_rd_addr_o=cur_ptr for exactly one cycle, then go to WAIT.
  - WAIT: hold until mem_rd_valid_i. Latch data, eop and next_ptr, then go to SEND. mem_rd_valid_i outside WAIT is ignored. Memory latency is arbitrary, with one outstanding read.
  - SEND: tx_valid_o=1, with tx_data_o and tx_last_o=eop stable until tx_ready_i.
    - On handshake, if eop go to DONE.
    - Otherwise set cur_ptr=next_ptr and go to FETCH.
  - DONE: frame_done_o=1 and frame_done_ptr_o=start_reg for one cycle, then go to IDLE.
- Latency: push at N gives mem_rd_en_o at N+2. With 1-cycle memory (valid at N+3), tx_valid_o rises at N+4.
- Single-cell frame: tx_last_o is set on the first beat.
- tx_valid_o never drops without a handshake. tx_ready_i is ignored outside SEND.

Optional Feature:
- Macro: EGRESS_IFG_EN.
- Defined:
  - DONE goes to a GAP state that counts IFG_CYCLES cycles with tx_valid_o=0.
  - GAP then goes to IDLE, so the minimum spacing between tx_last_o and the next frame's first beat includes IFG_CYCLES idle cycles.
  - The FIFO still accepts pushes during GAP.
- Undefined: DONE goes directly to IDLE and IFG_CYCLES is unused.

Test Plan:
- Push ptr 0x10 at cycle 5; memory at 1-cycle latency returns 0x10 data 0xAA with eop=1.
  -> mem_rd_en_o at 7 with addr 0x10.
  -> tx beat 0xAA with tx_last_o=1 at 9.
  -> frame_done_o with ptr 0x10 at 10.
- Three-cell chain 0x20->0x21->0x35 (data 0x01/0x02/0x03, eop on 0x35).
  -> reads issued in order 0x20, 0x21, 0x35.
  -> tx 0x01, 0x02, 0x03 with tx_last_o only on the third beat.
- Hold tx_ready_i=0 for 5 cycles during SEND.
  -> tx_valid_o and tx_data_o are held stable.
  -> no new mem_rd_en_o is issued.
- Push 17 pointers back-to-back with tx_ready_i=0 and QUEUE_DEPTH=16.
  -> queue_full_o asserts and drop_o pulses once for the rejected push.
  -> queue_count_o stays at 16 until a pop.
- Assert rst_n=0 mid-frame in WAIT.
  -> all outputs are 0 immediately and queue_count_o is 0.
  -> no frame_done_o is issued.
  -> a post-reset push of ptr 0x40 is processed normally.
- EGRESS_IFG_EN with IFG_CYCLES=12 and two queued single-cell frames.
  -> at least 12 cycles with tx_valid_o=0 between the first tx_last_o and the second frame's beat.
